control_sequencer: RTL and testbench

//  Multi-cycle accumulator-machine sequencer; it is the issuing side of the ALU interface.

---
 rtl/control_sequencer_pkg.sv | 37 +++
 rtl/control_sequencer_cs_decode.sv | 30 +++
 rtl/control_sequencer.sv | 131 +++++++++++++
 tb/tb_control_sequencer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the accumulator-machine sequencer.
// Opcodes match the ALU's OP_* encoding; instruction = {opcode, addr}.
package control_sequencer_pkg;

  localparam int CS_SIZE   = 8;
  localparam int CS_ADDR_W = 5;
  localparam int CS_PC_W   = 8;
  localparam int OP_W      = 3;

  localparam int INSTR_OP_LSB = CS_ADDR_W;
  localparam int INSTR_OP_MSB = CS_ADDR_W + OP_W - 1;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_NOT = 3'd5;
  localparam logic [OP_W-1:0] OP_LD  = 3'd6;
  localparam logic [OP_W-1:0] OP_ST  = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    OPERAND,
    EXECUTE,
    WRITEBACK
  } cs_state_e;

  typedef struct packed {
    logic needs_operand;
    logic is_store;
    logic writes_carry;
  } cs_dec_t;

endpackage

// File: rtl/control_sequencer_cs_decode.sv
// Opcode classifier for the sequencer.
// op_i: opcode; dec_o: {needs_operand, is_store, writes_carry}.
module cs_decode
  import control_sequencer_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output cs_dec_t         dec_o
);

  always_comb begin
    dec_o.needs_operand = 1'b1;
    dec_o.is_store      = 1'b0;
    dec_o.writes_carry  = 1'b0;
    unique case (1'b1)
      (op_i == OP_NOT): begin
        dec_o.needs_operand = 1'b0;
      end
      (op_i == OP_ST): begin
        dec_o.needs_operand = 1'b0;
        dec_o.is_store      = 1'b1;
      end
      (op_i == OP_ADD),
      (op_i == OP_SUB): begin
        dec_o.writes_carry = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle accumulator sequencer driving an external ALU.
// Ports: CLK/RST_N/RUN control; imem_* fetch; dmem_* data; alu_* ALU; acc/carry_flag/pc/busy/instr_done status.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int SIZE   = CS_SIZE,
  parameter int ADDR_W = CS_ADDR_W,
  parameter int PC_W   = CS_PC_W
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   RUN,
  output logic                   imem_req,
  output logic [PC_W-1:0]        imem_addr,
  input  logic [OP_W+ADDR_W-1:0] imem_rdata,
  input  logic                   imem_valid,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [ADDR_W-1:0]      dmem_addr,
  output logic [SIZE-1:0]        dmem_wdata,
  input  logic [SIZE-1:0]        dmem_rdata,
  input  logic                   dmem_ack,
  output logic                   alu_ce,
  output logic [OP_W-1:0]        alu_op_code,
  output logic [SIZE-1:0]        alu_left,
  output logic [SIZE-1:0]        alu_right,
  input  logic [SIZE-1:0]        alu_result,
  input  logic                   alu_carry,
  output logic [SIZE-1:0]        acc,
  output logic                   carry_flag,
  output logic [PC_W-1:0]        pc,
  output logic                   busy,
  output logic                   instr_done
);

  localparam int IW = OP_W + ADDR_W;

  cs_state_e       state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [IW-1:0]   ir_q;
  logic [SIZE-1:0] opr_q;
  logic [SIZE-1:0] res_q;
  logic [SIZE-1:0] acc_q;
  logic            cres_q;
  logic            carry_q;
  logic [OP_W-1:0] op;
  cs_dec_t         dec;
  logic            retire;
  logic            in_wb;

  assign op     = ir_q[IW-1:ADDR_W];
  assign pc_d   = pc_q + PC_W'(1);
  assign in_wb  = (state_q == WRITEBACK);
  // Stores retire on the write ack; everything else retires in one WB cycle.
  assign retire = in_wb && (!dec.is_store || dmem_ack);

  cs_decode u_decode (
    .op_i  (op),
    .dec_o (dec)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      opr_q   <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      cres_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (RUN) state_q <= FETCH;
        end
        FETCH: begin
          if (imem_valid) begin
            ir_q    <= imem_rdata;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          state_q <= dec.needs_operand ? OPERAND : EXECUTE;
        end
        OPERAND: begin
          if (dmem_ack) begin
            opr_q   <= dmem_rdata;
            state_q <= EXECUTE;
          end
        end
        EXECUTE: begin
          res_q   <= alu_result;
          cres_q  <= alu_carry;
          state_q <= WRITEBACK;
        end
        WRITEBACK: begin
          if (retire) begin
            if (!dec.is_store) begin
              acc_q <= res_q;
              if (dec.writes_carry) carry_q <= cres_q;
            end
            pc_q    <= pc_d;
            state_q <= RUN ? FETCH : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register, so they
  // fall asynchronously with reset and stay stable while waiting.
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign dmem_req    = (state_q == OPERAND) || (in_wb && dec.is_store);
  assign dmem_we     = in_wb && dec.is_store;
  assign dmem_addr   = ir_q[ADDR_W-1:0];
  assign dmem_wdata  = res_q;
  assign alu_ce      = (state_q == EXECUTE);
  assign alu_op_code = op;
  assign alu_left    = acc_q;
  assign alu_right   = opr_q;
  assign acc         = acc_q;
  assign carry_flag  = carry_q;
  assign pc          = pc_q;
  assign busy        = (state_q != IDLE);
  assign instr_done  = retire;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer.
// Memory and ALU models plus an expected-result queue per instruction.
module tb_control_sequencer;
  import control_sequencer_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       RUN = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       imem_valid;
  logic       dmem_req;
  logic       dmem_we;
  logic [4:0] dmem_addr;
  logic [7:0] dmem_wdata;
  logic [7:0] dmem_rdata;
  logic       dmem_ack;
  logic       alu_ce;
  logic [2:0] alu_op_code;
  logic [7:0] alu_left;
  logic [7:0] alu_right;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic [7:0] acc;
  logic       carry_flag;
  logic [7:0] pc;
  logic       busy;
  logic       instr_done;

  logic [7:0] imem [0:255];
  logic [7:0] dmem [0:31];
  int imem_wait = 0;
  int dmem_wait = 0;
  int icnt = 0;
  int dcnt = 0;
  bit force_ack = 1'b0;
  bit force_valid = 1'b0;
  int wr_cnt = 0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_data = '0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] acc;
    logic       c;
    logic [7:0] pc;
    int         cyc;
    int         dreq;
  } exp_t;
  exp_t sb[$];

  always #5 CLK = ~CLK;

  control_sequencer #(.SIZE(8), .ADDR_W(5), .PC_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .RUN(RUN),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .alu_ce(alu_ce), .alu_op_code(alu_op_code),
    .alu_left(alu_left), .alu_right(alu_right),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .acc(acc), .carry_flag(carry_flag), .pc(pc),
    .busy(busy), .instr_done(instr_done)
  );

  assign imem_rdata = imem[imem_addr];
  assign dmem_rdata = dmem[dmem_addr];
  assign imem_valid = (imem_req && icnt >= imem_wait) || force_valid;
  assign dmem_ack   = (dmem_req && dcnt >= dmem_wait) || force_ack;

  always @(posedge CLK) begin
    icnt <= (imem_req && !imem_valid) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dmem_req && dmem_ack && dmem_we) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= dmem_addr;
      wr_data <= dmem_wdata;
    end
  end

  // Reference ALU: SUB carry is the borrow (left < right).
  always_comb begin
    alu_result = '0;
    alu_carry  = 1'b0;
    case (alu_op_code)
      OP_ADD: {alu_carry, alu_result} = {1'b0, alu_left} + {1'b0, alu_right};
      OP_SUB: {alu_carry, alu_result} = {1'b0, alu_left} - {1'b0, alu_right};
      OP_AND: alu_result = alu_left & alu_right;
      OP_OR:  alu_result = alu_left | alu_right;
      OP_XOR: alu_result = alu_left ^ alu_right;
      OP_NOT: alu_result = ~alu_left;
      OP_LD:  alu_result = alu_right;
      OP_ST:  alu_result = alu_left;
      default: ;
    endcase
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ins(logic [2:0] op, logic [4:0] a);
    return {op, a};
  endfunction

  task automatic do_reset();
    RST_N = 1'b0;
    RUN = 1'b0;
    force_ack = 1'b0;
    force_valid = 1'b0;
    imem_wait = 0;
    dmem_wait = 0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic start_run();
    @(negedge CLK);
    RUN = 1'b1;
  endtask

  // Waits for one retirement; returns cycle count and dmem activity.
  task automatic wait_retire(input int stop_at, output int cyc,
                             output int dreq, output bit ok,
                             output logic [4:0] da, output logic [7:0] dwd,
                             output logic dwe, output bit stable);
    bit first;
    cyc = 0; dreq = 0; ok = 0; stable = 1; first = 1;
    da = '0; dwd = '0; dwe = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      cyc++;
      if (cyc == stop_at) RUN = 1'b0;
      if (dmem_req) begin
        if (!first && (dmem_addr !== da || dmem_wdata !== dwd
                       || dmem_we !== dwe)) stable = 0;
        da = dmem_addr; dwd = dmem_wdata; dwe = dmem_we;
        first = 0;
        dreq++;
      end
      if (instr_done) begin
        ok = 1;
        break;
      end
    end
    if (ok) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge CLK);
    checks++;
    if ({busy, imem_req, dmem_req, alu_ce, instr_done} !== 5'b0) begin
      failures++;
      $display("FAIL rst_ctl got=%b exp=00000",
               {busy, imem_req, dmem_req, alu_ce, instr_done});
    end
    checks++;
    if ({pc, acc, carry_flag} !== 17'h0) begin
      failures++;
      $display("FAIL rst_regs pc=%h acc=%h c=%b exp=0", pc, acc, carry_flag);
    end
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL rst_idle busy=%b req=%b exp=0", busy, imem_req);
    end
  endtask

  task automatic test_load();
    int cyc, dreq; bit ok, st; logic [4:0] da; logic [7:0] dwd; logic dwe;
    exp_t e;
    do_reset();
    imem[0] = ins(OP_LD, 5'd3);
    dmem[3] = 8'h2A;
    start_run();
    sb.push_back('{8'h2A, 1'b0, 8'd1, 5, 1});
    wait_retire(1, cyc, dreq, ok, da, dwd, dwe, st);
    e = sb.pop_front();
    checks++;
    if (!ok) begin failures++; $display("FAIL ld_done timeout"); end
    checks++;
    if (cyc != e.cyc) begin
      failures++; $display("FAIL ld_cycles got=%0d exp=%0d", cyc, e.cyc);
    end
    checks++;
    if (dreq != e.dreq || da !== 5'd3 || dwe !== 1'b0) begin
      failures++;
      $display("FAIL ld_dmem n=%0d addr=%0d we=%b exp n=1 addr=3 we=0",
               dreq, da, dwe);
    end
    checks++;
    if (acc !== e.acc || pc !== e.pc || carry_flag !== e.c) begin
      failures++;
      $display("FAIL ld_state acc=%h pc=%h c=%b exp acc=%h pc=%h c=%b",
               acc, pc, carry_flag, e.acc, e.pc, e.c);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL ld_idle busy=%b exp=0", busy);
    end
  endtask

  task automatic test_add_and();
    int cyc, dreq; bit ok, st; logic [4:0] da; logic [7:0] dwd; logic dwe;
    exp_t e;
    do_reset();
    imem[0] = ins(OP_LD, 5'd5);
    imem[1] = ins(OP_ADD, 5'd4);
    imem[2] = ins(OP_AND, 5'd6);
    dmem[5] = 8'hF0; dmem[4] = 8'h20; dmem[6] = 8'hFF;
    start_run();
    sb.push_back('{8'hF0, 1'b0, 8'd1, 5, 1});
    sb.push_back('{8'h10, 1'b1, 8'd2, 5, 1});
    sb.push_back('{8'h10, 1'b1, 8'd3, 5, 1});
    for (int i = 0; i < 3; i++) begin
      wait_retire((i == 2) ? 1 : 0, cyc, dreq, ok, da, dwd, dwe, st);
      e = sb.pop_front();
      checks++;
      if (!ok || cyc != e.cyc || dreq != e.dreq) begin
        failures++;
        $display("FAIL add_timing[%0d] ok=%b cyc=%0d dreq=%0d exp cyc=%0d dreq=%0d",
                 i, ok, cyc, dreq, e.cyc, e.dreq);
      end
      checks++;
      if (acc !== e.acc || carry_flag !== e.c || pc !== e.pc) begin
        failures++;
        $display("FAIL add_state[%0d] acc=%h c=%b pc=%h exp acc=%h c=%b pc=%h",
                 i, acc, carry_flag, pc, e.acc, e.c, e.pc);
      end
    end
  endtask

  task automatic test_sub_not();
    int cyc, dreq; bit ok, st; logic [4:0] da; logic [7:0] dwd; logic dwe;
    exp_t e;
    do_reset();
    imem[0] = ins(OP_LD, 5'd7);
    imem[1] = ins(OP_SUB, 5'd8);
    imem[2] = ins(OP_NOT, 5'd0);
    dmem[7] = 8'h05; dmem[8] = 8'h07;
    start_run();
    sb.push_back('{8'h05, 1'b0, 8'd1, 5, 1});
    sb.push_back('{8'hFE, 1'b1, 8'd2, 5, 1});
    sb.push_back('{8'h01, 1'b1, 8'd3, 4, 0});
    for (int i = 0; i < 3; i++) begin
      wait_retire((i == 2) ? 1 : 0, cyc, dreq, ok, da, dwd, dwe, st);
      e = sb.pop_front();
      checks++;
      if (!ok || cyc != e.cyc || dreq != e.dreq) begin
        failures++;
        $display("FAIL sub_timing[%0d] ok=%b cyc=%0d dreq=%0d exp cyc=%0d dreq=%0d",
                 i, ok, cyc, dreq, e.cyc, e.dreq);
      end
      checks++;
      if (acc !== e.acc || carry_flag !== e.c || pc !== e.pc) begin
        failures++;
        $display("FAIL sub_state[%0d] acc=%h c=%b pc=%h exp acc=%h c=%b pc=%h",
                 i, acc, carry_flag, pc, e.acc, e.c, e.pc);
      end
    end
  endtask

  task automatic test_store();
    int cyc, dreq, w0; bit ok, st; logic [4:0] da; logic [7:0] dwd; logic dwe;
    exp_t e;
    do_reset();
    dmem_wait = 3;
    imem[0] = ins(OP_LD, 5'd10);
    imem[1] = ins(OP_ST, 5'd9);
    dmem[10] = 8'h3C;
    w0 = wr_cnt;
    start_run();
    sb.push_back('{8'h3C, 1'b0, 8'd1, 8, 4});
    sb.push_back('{8'h3C, 1'b0, 8'd2, 7, 4});
    for (int i = 0; i < 2; i++) begin
      wait_retire((i == 1) ? 1 : 0, cyc, dreq, ok, da, dwd, dwe, st);
      e = sb.pop_front();
      checks++;
      if (!ok || cyc != e.cyc || dreq != e.dreq || !st) begin
        failures++;
        $display("FAIL st_timing[%0d] ok=%b cyc=%0d dreq=%0d stable=%b exp cyc=%0d dreq=%0d",
                 i, ok, cyc, dreq, st, e.cyc, e.dreq);
      end
      checks++;
      if (acc !== e.acc || carry_flag !== e.c || pc !== e.pc) begin
        failures++;
        $display("FAIL st_state[%0d] acc=%h c=%b pc=%h exp acc=%h c=%b pc=%h",
                 i, acc, carry_flag, pc, e.acc, e.c, e.pc);
      end
    end
    checks++;
    if (da !== 5'd9 || dwe !== 1'b1 || dwd !== 8'h3C) begin
      failures++;
      $display("FAIL st_bus addr=%0d we=%b wdata=%h exp addr=9 we=1 wdata=3c",
               da, dwe, dwd);
    end
    checks++;
    if (wr_cnt != w0 + 1 || wr_addr !== 5'd9 || wr_data !== 8'h3C) begin
      failures++;
      $display("FAIL st_write n=%0d addr=%0d data=%h exp n=%0d addr=9 data=3c",
               wr_cnt - w0, wr_addr, wr_data, 1);
    end
  endtask

  task automatic test_pc_wrap();
    int cyc, dreq, bad, seen; bit ok, st; logic [4:0] da; logic [7:0] dwd;
    logic dwe;
    exp_t e;
    do_reset();
    for (int a = 0; a < 256; a++) imem[a] = ins(OP_NOT, 5'd0);
    imem[255] = ins(OP_LD, 5'd11);
    dmem[11] = 8'h77;
    bad = 0;
    start_run();
    for (int i = 0; i < 255; i++) begin
      wait_retire(0, cyc, dreq, ok, da, dwd, dwe, st);
      if (!ok) begin bad++; break; end
    end
    checks++;
    if (bad != 0 || pc !== 8'd255 || acc !== 8'hFF) begin
      failures++;
      $display("FAIL wrap_pre bad=%0d pc=%h acc=%h exp pc=ff acc=ff", bad, pc, acc);
    end
    sb.push_back('{8'h77, 1'b0, 8'd0, 5, 1});
    wait_retire(4, cyc, dreq, ok, da, dwd, dwe, st);
    e = sb.pop_front();
    checks++;
    if (!ok || cyc != e.cyc) begin
      failures++;
      $display("FAIL wrap_timing ok=%b cyc=%0d exp=%0d", ok, cyc, e.cyc);
    end
    checks++;
    if (pc !== e.pc || acc !== e.acc || busy !== 1'b0) begin
      failures++;
      $display("FAIL wrap_state pc=%h acc=%h busy=%b exp pc=%h acc=%h busy=0",
               pc, acc, busy, e.pc, e.acc);
    end
    seen = 0;
    repeat (6) begin
      @(negedge CLK);
      if (imem_req || busy) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++; $display("FAIL wrap_stopped active=%0d exp=0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, dreq; bit ok, st, hit; logic [4:0] da; logic [7:0] dwd; logic dwe;
    do_reset();
    imem[0] = ins(OP_LD, 5'd3);
    imem[1] = ins(OP_LD, 5'd12);
    dmem[3] = 8'h2A; dmem[12] = 8'h55;
    start_run();
    wait_retire(1, cyc, dreq, ok, da, dwd, dwe, st);
    checks++;
    if (!ok || acc !== 8'h2A || pc !== 8'd1) begin
      failures++;
      $display("FAIL rmid_pre ok=%b acc=%h pc=%h exp acc=2a pc=01", ok, acc, pc);
    end
    dmem_wait = 50;
    start_run();
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (dmem_req) begin hit = 1; break; end
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL rmid_wait no dmem_req"); end
    RST_N = 1'b0;
    #1;
    checks++;
    if ({dmem_req, imem_req, alu_ce, busy, instr_done} !== 5'b0) begin
      failures++;
      $display("FAIL rmid_async got=%b exp=00000",
               {dmem_req, imem_req, alu_ce, busy, instr_done});
    end
    checks++;
    if ({pc, acc, carry_flag} !== 17'h0) begin
      failures++;
      $display("FAIL rmid_regs pc=%h acc=%h c=%b exp=0", pc, acc, carry_flag);
    end
    RUN = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    force_ack = 1'b1;
    force_valid = 1'b1;
    @(negedge CLK);
    force_ack = 1'b0;
    force_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || pc !== 8'd0 || acc !== 8'h0 || dmem_req !== 1'b0) begin
      failures++;
      $display("FAIL rmid_late busy=%b pc=%h acc=%h dreq=%b exp all 0",
               busy, pc, acc, dmem_req);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) imem[a] = '0;
    for (int a = 0; a < 32; a++) dmem[a] = '0;
    test_reset();
    test_load();
    test_add_and();
    test_sub_not();
    test_store();
    test_pc_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
